// File: rtl/qea_host_ctrl.sv
// Host-side sequencer for the QEA core. It streams gate context into the core,
// seeds the state RAM with |0>, starts and times a run, then reads every state word back.
module qea_host_ctrl #(
  parameter int PE_NUM                  = 4,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter logic [STATE_DATA_WIDTH-1:0] INIT_AMP = 64'h40000000_00000000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_start,
  input  logic [MAX_QBIT_WIDTH-1:0]            cfg_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   cfg_ins_num,
  input  logic                                 s_ctx_valid,
  output logic                                 s_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   s_ctx_data,
  output logic                                 o_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic [PE_NUM-1:0]                    o_state_ena,
  output logic [PE_NUM-1:0]                    o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic                                 i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  output logic                                 m_res_valid,
  input  logic                                 m_res_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   m_res_data,
  output logic [STATE_ADDR_WIDTH-1:0]          m_res_addr,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [31:0]                          o_cycles
);

  localparam int SW  = PE_NUM * STATE_DATA_WIDTH;
  localparam int SAW = STATE_ADDR_WIDTH;
  localparam int CAW = GATE_CONTEXT_ADDR_WIDTH;
  localparam logic [SW-1:0] INIT_WORD = SW'(INIT_AMP) << (SW - STATE_DATA_WIDTH);

  typedef enum logic [3:0] {
    IDLE, LOAD_CTX, LOAD_STATE, START, RUN, RD_ISSUE, RD_WAIT, RD_HOLD, DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [MAX_QBIT_WIDTH-1:0]      qbit_q, qbit_d;
  logic [CAW-1:0]                 ins_q, ins_d, ctx_cnt_q, ctx_cnt_d;
  logic [SAW-1:0]                 k_q, k_d;
  logic [1:0]                     run_q, run_d;
  logic [31:0]                    cyc_q, cyc_d, cyc_inc;
  logic                           ctx_en_q, ctx_en_d;
  logic [CAW-1:0]                 ctx_addr_q, ctx_addr_d;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_q, ctx_data_d;
  logic [SW-1:0]                  res_data_q, res_data_d;
  logic [SAW-1:0]                 res_addr_q, res_addr_d;
  logic                           err_q, err_d;

  logic                           cfg_ok, ctx_acc, st_wr, st_rd;
  logic [SAW:0]                   n_words;
  logic [SAW-1:0]                 last_k;

  assign cfg_ok  = (32'(cfg_qbit_num) >= 32'd2) &&
                   (32'(cfg_qbit_num) <= 32'(STATE_ADDR_WIDTH + 2));
  assign n_words = (SAW+1)'(1) << (qbit_q - MAX_QBIT_WIDTH'(2));
  assign last_k  = SAW'(n_words - (SAW+1)'(1));
  assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + 32'd1;

  // Ready drops once the count is reached; the extra LOAD_CTX cycle lets the last write land.
  assign s_ctx_ready = (state_q == LOAD_CTX) && (ctx_cnt_q != ins_q);
  assign ctx_acc     = s_ctx_valid && s_ctx_ready;

  always_comb begin
    state_d    = state_q;
    qbit_d     = qbit_q;
    ins_d      = ins_q;
    ctx_cnt_d  = ctx_cnt_q;
    k_d        = k_q;
    run_d      = run_q;
    cyc_d      = cyc_q;
    ctx_en_d   = 1'b0;
    ctx_addr_d = ctx_addr_q;
    ctx_data_d = ctx_data_q;
    res_data_d = res_data_q;
    res_addr_d = res_addr_q;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: if (cfg_start) begin
        if (cfg_ok) begin
          qbit_d    = cfg_qbit_num;
          ins_d     = cfg_ins_num;
          cyc_d     = '0;
          ctx_cnt_d = '0;
          k_d       = '0;
          state_d   = (cfg_ins_num == '0) ? LOAD_STATE : LOAD_CTX;
        end else begin
          err_d = 1'b1;
        end
      end
      LOAD_CTX: begin
        if (ctx_acc) begin
          ctx_en_d   = 1'b1;
          ctx_addr_d = ctx_cnt_q;
          ctx_data_d = s_ctx_data;
          ctx_cnt_d  = ctx_cnt_q + CAW'(1);
        end
        if (ctx_cnt_q == ins_q) state_d = LOAD_STATE;
      end
      LOAD_STATE: begin
        if (k_q == last_k) begin
          k_d     = '0;
          state_d = START;
        end else begin
          k_d = k_q + SAW'(1);
        end
      end
      START: begin
        cyc_d   = cyc_inc;
        run_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cyc_d = cyc_inc;
        // i_complete may still be high from the previous run for the first two cycles.
        if (run_q != 2'd2) run_d = run_q + 2'd1;
        else if (i_complete) state_d = RD_ISSUE;
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        res_data_d = i_state_dout;
        res_addr_d = k_q;
        state_d    = RD_HOLD;
      end
      RD_HOLD: if (m_res_ready) begin
        if (k_q == last_k) state_d = DONE;
        else begin
          k_d     = k_q + SAW'(1);
          state_d = RD_ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      qbit_q     <= '0;
      ins_q      <= '0;
      ctx_cnt_q  <= '0;
      k_q        <= '0;
      run_q      <= '0;
      cyc_q      <= '0;
      ctx_en_q   <= 1'b0;
      ctx_addr_q <= '0;
      ctx_data_q <= '0;
      res_data_q <= '0;
      res_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      qbit_q     <= qbit_d;
      ins_q      <= ins_d;
      ctx_cnt_q  <= ctx_cnt_d;
      k_q        <= k_d;
      run_q      <= run_d;
      cyc_q      <= cyc_d;
      ctx_en_q   <= ctx_en_d;
      ctx_addr_q <= ctx_addr_d;
      ctx_data_q <= ctx_data_d;
      res_data_q <= res_data_d;
      res_addr_q <= res_addr_d;
      err_q      <= err_d;
    end
  end

  assign st_wr = (state_q == LOAD_STATE);
  assign st_rd = (state_q == RD_ISSUE);

  assign o_start       = (state_q == START);
  assign o_qbit_num    = qbit_q;
  assign o_ctx_en      = ctx_en_q;
  assign o_ctx_wea     = ctx_en_q;
  assign o_ctx_addr    = ctx_addr_q;
  assign o_ctx_data    = ctx_data_q;
  assign o_state_ena   = {PE_NUM{st_wr | st_rd}};
  assign o_state_wea   = {PE_NUM{st_wr}};
  assign o_state_addra = (st_wr | st_rd) ? k_q : '0;
  assign o_state_dina  = (st_wr && k_q == '0) ? INIT_WORD : '0;
  assign m_res_valid   = (state_q == RD_HOLD);
  assign m_res_data    = res_data_q;
  assign m_res_addr    = res_addr_q;
  assign o_busy        = (state_q != IDLE);
  assign o_done        = (state_q == DONE);
  assign o_err         = err_q;
  assign o_cycles      = cyc_q;

endmodule
